// File: rtl/reg_file_param_if.sv
// Register-file bus: write strobe/address/data, two read ports and the
// bulk-clear request/status group. Parameters must match the attached
// reg_file_param instance.
//
// Signalling: there is no valid/ready back-pressure. wr_en and clr_req are
// single-cycle strobes sampled at the rising clock edge. A write presented
// while clr_busy is high is discarded, and wr_drop flags it in the same cycle.
// A clr_req while a clear is already running (or finishing) is ignored.
interface reg_file_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_drop;

  // Control/decode side: drives addresses and strobes.
  modport master (
    output wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, clr_req,
    input  rd_a_data, rd_b_data, clr_busy, clr_done, wr_drop
  );

  // Register-file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, clr_req,
    output rd_a_data, rd_b_data, clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports
// with write-first bypass, optional hard-zero entry 0, and a sequenced
// bulk clear that walks every entry, one entry per cycle.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_param_if.slave   bus,
  output logic [1:0]        state_dbg
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_a_q;
  logic [DATA_W-1:0] rd_b_q;

  // The single effective write for this cycle: the clear sweep owns the port
  // while CLEAR, otherwise the external strobe. Entry 0 is never written when
  // it is hard-wired to zero.
  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic [DATA_W-1:0] rd_a_nxt;
  logic [DATA_W-1:0] rd_b_nxt;

  // Select the effective write source.
  always_comb begin
    eff_we   = 1'b0;
    eff_addr = '0;
    eff_data = '0;
    if (state == CLEAR) begin
      eff_we   = 1'b1;
      eff_addr = cnt;
      eff_data = '0;
    end else begin
      eff_we   = bus.wr_en;
      eff_addr = bus.wr_addr;
      eff_data = bus.wr_data;
    end
    if ((ZERO_REG != 0) && (eff_addr == '0)) begin
      eff_we = 1'b0;
    end
  end

  // Next read values: hard zero first, then write-first bypass, then storage.
  always_comb begin
    rd_a_nxt = mem[bus.rd_a_addr];
    rd_b_nxt = mem[bus.rd_b_addr];
    if (eff_we && (eff_addr == bus.rd_a_addr)) rd_a_nxt = eff_data;
    if (eff_we && (eff_addr == bus.rd_b_addr)) rd_b_nxt = eff_data;
    if ((ZERO_REG != 0) && (bus.rd_a_addr == '0)) rd_a_nxt = '0;
    if ((ZERO_REG != 0) && (bus.rd_b_addr == '0)) rd_b_nxt = '0;
  end

  // Storage array: cleared by reset, written by the effective write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (eff_we) begin
      mem[eff_addr] <= eff_data;
    end
  end

  // Registered read ports, never stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_nxt;
      rd_b_q <= rd_b_nxt;
    end
  end

  // Clear sequencer: IDLE -> CLEAR for exactly DEPTH cycles -> DONE -> IDLE.
  // Requests arriving in CLEAR or DONE are dropped rather than queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decode straight from the state register.
  assign bus.clr_busy  = (state == CLEAR);
  assign bus.clr_done  = (state == DONE);
  assign bus.wr_drop   = bus.wr_en & (state == CLEAR);
  assign bus.rd_a_data = rd_a_q;
  assign bus.rd_b_data = rd_b_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (plain and hard-zero entry 0)
// share one stimulus stream and are checked against array models.
module tb_reg_file_param;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_a_addr = '0;
  logic [AW-1:0] rd_b_addr = '0;
  logic          clr_req = 1'b0;
  logic [1:0]    st0, st1;

  reg_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  reg_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.wr_en = wr_en;         assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr;     assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;     assign bus1.wr_data = wr_data;
  assign bus0.rd_a_addr = rd_a_addr; assign bus1.rd_a_addr = rd_a_addr;
  assign bus0.rd_b_addr = rd_b_addr; assign bus1.rd_b_addr = rd_b_addr;
  assign bus0.clr_req = clr_req;     assign bus1.clr_req = clr_req;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .state_dbg(st0)
  );
  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .state_dbg(st1)
  );

  // ---------------- reference model ----------------
  // m0/m1: contents of each instance. clr_left: clear cycles still to run.
  // done_flag: the cycle following the last clear cycle.
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];
  int clr_left = 0;
  bit done_flag = 1'b0;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    clr_left  = 0;
    done_flag = 1'b0;
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, check wr_drop, clock, advance model, check outputs.
  task automatic step(input bit we, input int wa, input int wd,
                      input int ra, input int rb, input bit cr);
    bit busy;
    bit e0, e1;
    int ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] xa0, xb0, xa1, xb1;
    wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
    rd_a_addr = AW'(ra); rd_b_addr = AW'(rb); clr_req = cr;
    #1;
    busy = (clr_left > 0);
    chk("wr_drop0", 32'(bus0.wr_drop), 32'(we && busy));
    chk("wr_drop1", 32'(bus1.wr_drop), 32'(we && busy));
    @(posedge clk);
    if (busy) begin
      ea = DEPTH - clr_left; ed = '0; e0 = 1'b1; e1 = 1'b1;
    end else begin
      ea = wa; ed = DW'(wd); e0 = we; e1 = we && (wa != 0);
    end
    xa0 = (e0 && ea == ra) ? ed : m0[ra];
    xb0 = (e0 && ea == rb) ? ed : m0[rb];
    xa1 = (ra == 0) ? '0 : ((e1 && ea == ra) ? ed : m1[ra]);
    xb1 = (rb == 0) ? '0 : ((e1 && ea == rb) ? ed : m1[rb]);
    if (e0) m0[ea] = ed;
    if (e1) m1[ea] = ed;
    if (busy) begin
      clr_left--;
      if (clr_left == 0) done_flag = 1'b1;
    end else if (done_flag) begin
      done_flag = 1'b0;
    end else if (cr) begin
      clr_left = DEPTH;
    end
    exp_q.push_back(xa0); exp_q.push_back(xb0);
    exp_q.push_back(xa1); exp_q.push_back(xb1);
    #1;
    chk("rd_a0", 32'(bus0.rd_a_data), 32'(exp_q.pop_front()));
    chk("rd_b0", 32'(bus0.rd_b_data), 32'(exp_q.pop_front()));
    chk("rd_a1", 32'(bus1.rd_a_data), 32'(exp_q.pop_front()));
    chk("rd_b1", 32'(bus1.rd_b_data), 32'(exp_q.pop_front()));
    chk("clr_busy0", 32'(bus0.clr_busy), 32'(clr_left > 0));
    chk("clr_busy1", 32'(bus1.clr_busy), 32'(clr_left > 0));
    chk("clr_done0", 32'(bus0.clr_done), 32'(done_flag));
    chk("clr_done1", 32'(bus1.clr_done), 32'(done_flag));
  endtask

  // Assert reset mid-cycle, check outputs drop immediately, release on negedge.
  task automatic async_reset();
    wr_en = 1'b0; clr_req = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_a0", 32'(bus0.rd_a_data), 32'h0);
    chk("rst_rd_b0", 32'(bus0.rd_b_data), 32'h0);
    chk("rst_rd_a1", 32'(bus1.rd_a_data), 32'h0);
    chk("rst_busy0", 32'(bus0.clr_busy), 32'h0);
    chk("rst_done0", 32'(bus0.clr_done), 32'h0);
    chk("rst_busy1", 32'(bus1.clr_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, i, (i + 8) % DEPTH, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cycles;
    model_reset();
    repeat (2) @(posedge clk);
    async_reset();
    read_all();

    // Plain write then read, with a prior value in entry 7 for the bypass test.
    step(1, 7, 8'h11, 0, 0, 0);
    step(1, 3, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 3, 7, 0);
    chk("wr_rd_a5", 32'(bus0.rd_a_data), 32'hA5);
    chk("pre_11", 32'(bus0.rd_b_data), 32'h11);

    // Write-first bypass on both ports to the same address.
    step(1, 7, 8'h3C, 7, 7, 0);
    chk("byp_a", 32'(bus0.rd_a_data), 32'h3C);
    chk("byp_b", 32'(bus0.rd_b_data), 32'h3C);

    // Entry 0 writes: stored in dut0, discarded by dut1 even on bypass.
    step(1, 0, 8'hFF, 0, 0, 0);
    chk("z_byp1", 32'(bus1.rd_a_data), 32'h0);
    chk("z_byp0", 32'(bus0.rd_a_data), 32'hFF);
    step(0, 0, 0, 0, 3, 0);
    chk("z_rd1", 32'(bus1.rd_a_data), 32'h0);

    // Fill with 0xFF, then clear; writes during busy dropped, extra request ignored.
    for (int i = 0; i < DEPTH; i++) step(1, i, 8'hFF, i, 0, 0);
    step(1, 2, 8'h55, 2, 2, 1);
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (bus0.clr_busy) busy_cycles++;
      step(1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
           $urandom_range(0, DEPTH - 1), i % DEPTH, (i == 4));
    end
    chk("busy_len", 32'(busy_cycles), 32'(DEPTH));
    read_all();

    // Reset five cycles into a clear, then confirm a fresh clear runs from entry 0.
    for (int i = 0; i < DEPTH; i++) step(1, i, 8'hC0 + i, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, i, 5, 0);
    async_reset();
    read_all();
    for (int i = 0; i < DEPTH; i++) step(1, i, 8'h80 + i, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 0, i % DEPTH, (i + 1) % DEPTH, 0);

    // clr_req held high keeps re-triggering from IDLE.
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
           $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
           $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
           ($urandom_range(0, 29) == 0));
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
